// File: rtl/cbrt_ctrl.sv
// cbrt_ctrl: upstream sequencer around an owned iterative cube-root core.
// Accepts an 8-bit operand, restarts the core, waits for busy to fall (with
// watchdog) and hands the 3-bit result downstream over valid/ready.
// Optional macro CBRT_CTRL_EXACT_EN adds out_exact_o (result cubed == operand).
module cbrt_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_bi,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [2:0] out_data_bo,
  output logic       err_o,
`ifdef CBRT_CTRL_EXACT_EN
  output logic       out_exact_o,
`endif
  output logic [7:0] done_cnt_bo
);

  localparam logic [2:0] ST_INIT  = 3'd0;
  localparam logic [2:0] ST_IDLE  = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_OUT   = 3'd4;

  localparam logic [7:0] TimeoutVal = 8'(TIMEOUT_CYCLES);

  logic [2:0] r_state;
  logic [7:0] r_operand;
  logic [7:0] r_wd;
  logic [2:0] r_out_data;
  logic       r_out_valid;
  logic       r_err;
  logic [7:0] r_done_cnt;

  logic       w_start_pulse;
  logic [7:0] w_wd_inc;
  logic       w_wd_hit;

  // ---------------------------------------------------------------------------
  // Cube-root core: one 3-bit digit group per cycle, leading zero groups skipped,
  // so small operands finish sooner than large ones.
  // ---------------------------------------------------------------------------
  logic        w_core_rst;
  logic        w_core_busy;
  logic [7:0]  r_core_x;
  logic [2:0]  r_core_y;
  logic [1:0]  r_core_grp;
  logic        r_core_busy;
  logic [1:0]  w_init_grp;
  logic [2:0]  w_y2;
  logic [7:0]  w_y2e;
  logic [7:0]  w_b_base;
  logic [15:0] w_b;
  logic        w_ge;

  assign w_core_rst  = rst_i | w_start_pulse;
  assign w_core_busy = w_core_rst | r_core_busy;
  assign w_init_grp  = (|r_operand[7:6]) ? 2'd2 : ((|r_operand[5:3]) ? 2'd1 : 2'd0);
  assign w_y2        = {r_core_y[1:0], 1'b0};
  assign w_y2e       = {5'b0, w_y2};
  assign w_b_base    = 8'd3 * w_y2e * (w_y2e + 8'd1) + 8'd1;
  assign w_ge        = {8'b0, r_core_x} >= w_b;

  // Trial subtrahend (3y(y+1)+1) aligned to the current digit group.
  always_comb begin
    w_b = {8'b0, w_b_base};
    case (r_core_grp)
      2'd1:    w_b = {8'b0, w_b_base} << 3;
      2'd2:    w_b = {8'b0, w_b_base} << 6;
      default: w_b = {8'b0, w_b_base};
    endcase
  end

  // Core datapath: load on rst, then one restoring step per busy cycle.
  always_ff @(posedge clk_i) begin
    if (w_core_rst) begin
      r_core_x    <= r_operand;
      r_core_y    <= 3'd0;
      r_core_grp  <= w_init_grp;
      r_core_busy <= 1'b1;
    end else if (r_core_busy) begin
      if (w_ge) r_core_x <= r_core_x - w_b[7:0];
      r_core_y <= w_y2 | {2'b0, w_ge};
      if (r_core_grp == 2'd0) r_core_busy <= 1'b0;
      else                    r_core_grp  <= r_core_grp - 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  assign w_start_pulse = (r_state == ST_START);
  assign w_wd_inc      = r_wd + 8'd1;
  assign w_wd_hit      = (w_wd_inc == TimeoutVal);

  // Control FSM, watchdog, result register, error flag and completion counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_INIT;
      r_operand   <= 8'd0;
      r_wd        <= 8'd0;
      r_out_data  <= 3'd0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_done_cnt  <= 8'd0;
    end else begin
      case (r_state)
        ST_INIT: begin
          if (!w_core_busy) begin
            r_state <= ST_IDLE;
          end else if (w_wd_hit) begin
            // Core never settled after reset; flag it but stay usable.
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_IDLE: begin
          if (in_valid_i) begin
            r_operand <= in_data_bi;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_wd    <= 8'd0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!w_core_busy) begin
            r_out_data  <= r_core_y;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else if (w_wd_hit) begin
            r_out_data  <= 3'd0;
            r_err       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else begin
            r_wd <= w_wd_inc;
          end
        end
        ST_OUT: begin
          if (out_ready_i) begin
            r_out_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + 8'd1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

`ifdef CBRT_CTRL_EXACT_EN
  logic [8:0] w_y9;
  logic [8:0] w_cube;
  logic       r_exact;

  assign w_y9   = {6'b0, r_core_y};
  assign w_cube = w_y9 * w_y9 * w_y9;

  // Exactness flag captured alongside the result; a timeout is never exact.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_exact <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (!w_core_busy)  r_exact <= (w_cube == {1'b0, r_operand});
      else if (w_wd_hit) r_exact <= 1'b0;
    end else if (r_state == ST_OUT && out_ready_i) begin
      r_exact <= 1'b0;
    end
  end

  assign out_exact_o = r_exact;
`endif

  assign in_ready_o  = (r_state == ST_IDLE);
  assign out_valid_o = r_out_valid;
  assign out_data_bo = r_out_data;
  assign err_o       = r_err;
  assign done_cnt_bo = r_done_cnt;

endmodule

// File: tb/tb_cbrt_ctrl.sv
// Directed self-checking bench for cbrt_ctrl. A second instance built with
// TIMEOUT_CYCLES=3 exercises the watchdog path.
module tb_cbrt_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid, in_ready, out_valid, out_ready, err;
  logic [7:0] in_data, done_cnt;
  logic [2:0] out_data;
  logic       t_in_valid, t_in_ready, t_out_valid, t_out_ready, t_err;
  logic [7:0] t_in_data, t_done_cnt;
  logic [2:0] t_out_data;
`ifdef CBRT_CTRL_EXACT_EN
  logic       out_exact, t_out_exact;
`endif

  int total = 0;
  int bad   = 0;

  cbrt_ctrl dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_bi (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_bo(out_data),
    .err_o      (err),
`ifdef CBRT_CTRL_EXACT_EN
    .out_exact_o(out_exact),
`endif
    .done_cnt_bo(done_cnt)
  );

  cbrt_ctrl #(.TIMEOUT_CYCLES(3)) dut_t (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (t_in_valid),
    .in_ready_o (t_in_ready),
    .in_data_bi (t_in_data),
    .out_valid_o(t_out_valid),
    .out_ready_i(t_out_ready),
    .out_data_bo(t_out_data),
    .err_o      (t_err),
`ifdef CBRT_CTRL_EXACT_EN
    .out_exact_o(t_out_exact),
`endif
    .done_cnt_bo(t_done_cnt)
  );

  // Offer one operand and wait (bounded) for it to be accepted.
  task automatic send(input bit sel, input logic [7:0] op, output bit ok);
    ok = 1'b0;
    if (sel) begin t_in_valid = 1'b1; t_in_data = op; end
    else     begin in_valid   = 1'b1; in_data   = op; end
    for (int i = 0; i < 100; i++) begin
      if ((sel ? t_in_ready : in_ready) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    if (sel) t_in_valid = 1'b0;
    else     in_valid   = 1'b0;
  endtask

  // Accept one result (bounded wait); returns data, error flag and exact flag.
  task automatic recv(input bit sel, output logic [2:0] data, output logic e,
                      output logic ex, output bit ok);
    ok = 1'b0;
    data = 3'bx; e = 1'bx; ex = 1'b1;
    if (sel) t_out_ready = 1'b1;
    else     out_ready   = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if ((sel ? t_out_valid : out_valid) === 1'b1) begin
        ok   = 1'b1;
        data = sel ? t_out_data : out_data;
        e    = sel ? t_err : err;
`ifdef CBRT_CTRL_EXACT_EN
        ex   = sel ? t_out_exact : out_exact;
`endif
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    t_out_ready = 1'b0;
    out_ready   = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 || done_cnt !== 8'd0 ||
        out_data !== 3'd0) begin
      bad++;
      $display("FAIL reset_vals got rdy=%b vld=%b err=%b cnt=%0d data=%0d want 0 0 0 0 0",
               in_ready, out_valid, err, done_cnt, out_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL init_wait got in_ready=%b want 0", in_ready);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || t_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL init_done got in_ready=%b/%b want 1/1", in_ready, t_in_ready);
    end
  endtask

  task automatic test_stream;
    logic [7:0] ops [4];
    logic [2:0] exp [4];
    logic [2:0] d;
    logic       e, ex;
    bit         ok;
    ops = '{8'd0, 8'd8, 8'd27, 8'd64};
    exp = '{3'd0, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      send(1'b0, ops[i], ok);
      total++;
      if (ok !== 1'b1) begin bad++; $display("FAIL stream_accept op=%0d got=0 want=1", ops[i]); end
      recv(1'b0, d, e, ex, ok);
      total++;
      if (ok !== 1'b1 || d !== exp[i]) begin
        bad++;
        $display("FAIL stream_data op=%0d got=%0d want=%0d", ops[i], d, exp[i]);
      end
      total++;
      if (ex !== 1'b1) begin bad++; $display("FAIL stream_exact op=%0d got=%b want=1", ops[i], ex); end
    end
    total++;
    if (done_cnt !== 8'd4 || err !== 1'b0) begin
      bad++;
      $display("FAIL stream_cnt got cnt=%0d err=%b want cnt=4 err=0", done_cnt, err);
    end
  endtask

  task automatic test_backpressure;
    logic [2:0] d;
    logic       e, ex;
    bit         ok, seen, rdy_bad, data_bad;
    send(1'b0, 8'd27, ok);
    total++;
    if (ok !== 1'b1) begin bad++; $display("FAIL bp_accept27 got=0 want=1"); end
    in_valid = 1'b1; in_data = 8'd64; out_ready = 1'b0;
    seen = 1'b0; rdy_bad = 1'b0; data_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (in_ready !== 1'b0) rdy_bad = 1'b1;
      if (out_valid === 1'b1) seen = 1'b1;
      if (seen && (out_valid !== 1'b1 || out_data !== 3'd3)) data_bad = 1'b1;
    end
    total++;
    if (rdy_bad) begin bad++; $display("FAIL bp_in_ready got=1 want=0 while holding"); end
    total++;
    if (!seen || data_bad) begin
      bad++;
      $display("FAIL bp_hold got vld=%b data=%0d want vld=1 data=3 stable", out_valid, out_data);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || done_cnt !== 8'd5) begin
      bad++;
      $display("FAIL bp_handshake got vld=%b cnt=%0d want vld=0 cnt=5", out_valid, done_cnt);
    end
    send(1'b0, 8'd64, ok);
    recv(1'b0, d, e, ex, ok);
    total++;
    if (ok !== 1'b1 || d !== 3'd4 || done_cnt !== 8'd6) begin
      bad++;
      $display("FAIL bp_second got data=%0d cnt=%0d want data=4 cnt=6", d, done_cnt);
    end
  endtask

  task automatic test_timeout;
    logic [2:0] d;
    logic       e, ex;
    bit         ok;
    total++;
    if (t_err !== 1'b0) begin bad++; $display("FAIL to_pre_err got=%b want=0", t_err); end
    send(1'b1, 8'd64, ok);
    recv(1'b1, d, e, ex, ok);
    total++;
    if (ok !== 1'b1 || d !== 3'd0 || e !== 1'b1) begin
      bad++;
      $display("FAIL to_result got ok=%b data=%0d err=%b want ok=1 data=0 err=1", ok, d, e);
    end
`ifdef CBRT_CTRL_EXACT_EN
    total++;
    if (ex !== 1'b0) begin bad++; $display("FAIL to_exact got=%b want=0", ex); end
`endif
    send(1'b1, 8'd8, ok);
    recv(1'b1, d, e, ex, ok);
    total++;
    if (ok !== 1'b1 || d !== 3'd2 || e !== 1'b1 || t_done_cnt !== 8'd2) begin
      bad++;
      $display("FAIL to_follow got data=%0d err=%b cnt=%0d want data=2 err=1 cnt=2",
               d, e, t_done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    bit ok, seen;
    send(1'b0, 8'd27, ok);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || done_cnt !== 8'd0) begin
      bad++;
      $display("FAIL mid_reset got rdy=%b vld=%b cnt=%0d want 0 0 0", in_ready, out_valid,
               done_cnt);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen || in_ready !== 1'b1 || done_cnt !== 8'd0) begin
      bad++;
      $display("FAIL mid_recover got seen_vld=%b rdy=%b cnt=%0d want 0 1 0", seen, in_ready,
               done_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [2:0] d;
    logic       e, ex;
    bit         ok, any_bad;
    any_bad = 1'b0;
    for (int i = 0; i < 255; i++) begin
      send(1'b0, 8'd8, ok);
      if (!ok) any_bad = 1'b1;
      recv(1'b0, d, e, ex, ok);
      if (!ok || d !== 3'd2) any_bad = 1'b1;
    end
    total++;
    if (any_bad || done_cnt !== 8'd255) begin
      bad++;
      $display("FAIL wrap_255 got cnt=%0d seq_err=%b want cnt=255 seq_err=0", done_cnt, any_bad);
    end
    send(1'b0, 8'd8, ok);
    recv(1'b0, d, e, ex, ok);
    total++;
    if (ok !== 1'b1 || d !== 3'd2 || done_cnt !== 8'd0) begin
      bad++;
      $display("FAIL wrap_0 got data=%0d cnt=%0d want data=2 cnt=0", d, done_cnt);
    end
  endtask

  initial begin
    in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
    t_in_valid = 1'b0; t_in_data = 8'd0; t_out_ready = 1'b0;
    rst = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=stuck want=finish");
    $fatal(1, "simulation time limit");
  end

endmodule
